// File: rtl/bcd_setpoint_counter.sv
// rtl/bcd_setpoint_counter.sv - multi-digit BCD setpoint stepped by add/sub keys between MIN_VAL and MAX_VAL
// Hold-to-auto-repeat is built only when BCD_SETPOINT_AUTOREPEAT_EN is defined.
module bcd_setpoint_counter #(
  parameter int DIGITS        = 2,
  parameter int MIN_VAL       = 1,
  parameter int MAX_VAL       = 60,
  parameter int RST_VAL       = 2,
  parameter int WRAP          = 1,
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_add,
  input  logic                  key_sub,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   set_val,
  output logic                  at_min,
  output logic                  at_max,
  output logic                  step_p,
  output logic                  limit_p,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);
  localparam logic [W-1:0] RST_BCD = to_bcd(RST_VAL);

  if (MIN_VAL >= MAX_VAL || MAX_VAL >= 10**DIGITS || RST_VAL < MIN_VAL ||
      RST_VAL > MAX_VAL || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("bcd_setpoint_counter: illegal parameter set");
  end

  logic key_add_q, key_sub_q;
  logic inc_req, dec_req;
  logic rep_inc, rep_dec;
  logic do_inc, do_dec;

  assign inc_req = key_add & ~key_add_q & ~key_sub;
  assign dec_req = key_sub & ~key_sub_q & ~key_add;

`ifdef BCD_SETPOINT_AUTOREPEAT_EN
  localparam int RMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  rep_state_t      rep_state;
  logic            dir_up;
  logic [CW-1:0]   rep_cnt;
  logic            keep;
  logic            rep_fire;

  // The repeat only survives while exactly the latched key is down and no load intervenes.
  assign keep     = ~load & (dir_up ? (key_add & ~key_sub) : (key_sub & ~key_add));
  assign rep_fire = keep & (((rep_state == HOLD)   && (rep_cnt == CW'(HOLD_DELAY - 1))) ||
                            ((rep_state == REPEAT) && (rep_cnt == CW'(REPEAT_PERIOD - 1))));
  assign rep_inc  = rep_fire & dir_up;
  assign rep_dec  = rep_fire & ~dir_up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_state <= IDLE;
      dir_up    <= 1'b0;
      rep_cnt   <= '0;
    end else if (~load & (inc_req | dec_req)) begin
      rep_state <= HOLD;
      dir_up    <= inc_req;
      rep_cnt   <= '0;
    end else if (rep_state != IDLE && !keep) begin
      rep_state <= IDLE;
      rep_cnt   <= '0;
    end else begin
      case (rep_state)
        HOLD: begin
          if (rep_cnt == CW'(HOLD_DELAY - 1)) begin
            rep_cnt   <= '0;
            rep_state <= REPEAT;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rep_cnt == CW'(REPEAT_PERIOD - 1)) rep_cnt <= '0;
          else                                   rep_cnt <= rep_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  assign do_inc = inc_req | rep_inc;
  assign do_dec = dec_req | rep_dec;

  logic           digits_ok;
  logic           load_ok;
  logic [W-1:0]   next_val;
  logic           next_step, next_limit, next_err;

  // Valid BCD orders the same as plain binary, so range checks compare the raw vectors.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (load_val >= MIN_BCD) && (load_val <= MAX_BCD);
  end

  always_comb begin
    next_val   = set_val;
    next_step  = 1'b0;
    next_limit = 1'b0;
    next_err   = 1'b0;
    if (load) begin
      if (load_ok) begin
        next_val  = load_val;
        next_step = (load_val != set_val);
      end else begin
        next_err = 1'b1;
      end
    end else if (do_inc) begin
      if (set_val == MAX_BCD) begin
        next_limit = 1'b1;
        if (WRAP != 0) begin
          next_val  = MIN_BCD;
          next_step = 1'b1;
        end
      end else begin
        next_val  = bcd_inc(set_val);
        next_step = 1'b1;
      end
    end else if (do_dec) begin
      if (set_val == MIN_BCD) begin
        next_limit = 1'b1;
        if (WRAP != 0) begin
          next_val  = MAX_BCD;
          next_step = 1'b1;
        end
      end else begin
        next_val  = bcd_dec(set_val);
        next_step = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_val   <= RST_BCD;
      step_p    <= 1'b0;
      limit_p   <= 1'b0;
      load_err  <= 1'b0;
      key_add_q <= 1'b0;
      key_sub_q <= 1'b0;
    end else begin
      set_val   <= next_val;
      step_p    <= next_step;
      limit_p   <= next_limit;
      load_err  <= next_err;
      key_add_q <= key_add;
      key_sub_q <= key_sub;
    end
  end

  assign at_min = (set_val == MIN_BCD);
  assign at_max = (set_val == MAX_BCD);

endmodule

// File: tb/tb_bcd_setpoint_counter.sv
// tb/tb_bcd_setpoint_counter.sv - bench for bcd_setpoint_counter, wrap and saturate builds side by side
module tb_bcd_setpoint_counter;

  localparam int MIN_V = 1;
  localparam int MAX_V = 60;
  localparam int RST_V = 2;
  localparam int HD    = 8;
  localparam int RP    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_add = 1'b0;
  logic       key_sub = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] sv[2];
  logic       amin[2], amax[2], stp[2], lmp[2], lerr[2];

  always #5 clk = ~clk;

  bcd_setpoint_counter #(
    .DIGITS(2), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .RST_VAL(RST_V), .WRAP(1),
    .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut_wrap (
    .clk(clk), .rst(rst), .key_add(key_add), .key_sub(key_sub), .load(load),
    .load_val(load_val), .set_val(sv[0]), .at_min(amin[0]), .at_max(amax[0]),
    .step_p(stp[0]), .limit_p(lmp[0]), .load_err(lerr[0])
  );

  bcd_setpoint_counter #(
    .DIGITS(2), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .RST_VAL(RST_V), .WRAP(0),
    .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut_sat (
    .clk(clk), .rst(rst), .key_add(key_add), .key_sub(key_sub), .load(load),
    .load_val(load_val), .set_val(sv[1]), .at_min(amin[1]), .at_max(amax[1]),
    .step_p(stp[1]), .limit_p(lmp[1]), .load_err(lerr[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference model: setpoint as a plain integer, auto-repeat as a count of held cycles.
  int  mv[2];
  bit  pa, ps, act, mdir;
  int  h;
  bit  e_st[2], e_lim[2], e_err;

  task automatic model_reset();
    mv[0] = RST_V;
    mv[1] = RST_V;
    pa = 1'b0;
    ps = 1'b0;
    act = 1'b0;
    h = 0;
  endtask

  task automatic tick();
    int lv;
    bit ok, inc_e, dec_e, rinc, rdec;
    inc_e = key_add && !pa && !key_sub;
    dec_e = key_sub && !ps && !key_add;
    rinc = 1'b0;
    rdec = 1'b0;
    e_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_st[k] = 1'b0;
      e_lim[k] = 1'b0;
    end
    if (load) begin
      ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
      lv = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
      if (lv < MIN_V || lv > MAX_V) ok = 1'b0;
      act = 1'b0;
      e_err = !ok;
      for (int k = 0; k < 2; k++) begin
        if (ok) begin
          e_st[k] = (mv[k] != lv);
          mv[k] = lv;
        end
      end
    end else begin
`ifdef BCD_SETPOINT_AUTOREPEAT_EN
      if (inc_e || dec_e) begin
        act = 1'b1;
        mdir = inc_e;
        h = 0;
      end else if (act) begin
        if (mdir ? (key_add && !key_sub) : (key_sub && !key_add)) begin
          h++;
          if (h >= HD && (h - HD) % RP == 0) begin
            rinc = mdir;
            rdec = !mdir;
          end
        end else begin
          act = 1'b0;
        end
      end
`endif
      for (int k = 0; k < 2; k++) begin
        if (inc_e || rinc) begin
          if (mv[k] == MAX_V) begin
            e_lim[k] = 1'b1;
            if (k == 0) begin mv[k] = MIN_V; e_st[k] = 1'b1; end
          end else begin
            mv[k] = mv[k] + 1;
            e_st[k] = 1'b1;
          end
        end else if (dec_e || rdec) begin
          if (mv[k] == MIN_V) begin
            e_lim[k] = 1'b1;
            if (k == 0) begin mv[k] = MAX_V; e_st[k] = 1'b1; end
          end else begin
            mv[k] = mv[k] - 1;
            e_st[k] = 1'b1;
          end
        end
      end
    end
    pa = key_add;
    ps = key_sub;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("set_val[%0d]", k), sv[k], bcd(mv[k]));
      chk($sformatf("step_p[%0d]", k), stp[k], e_st[k]);
      chk($sformatf("limit_p[%0d]", k), lmp[k], e_lim[k]);
      chk($sformatf("load_err[%0d]", k), lerr[k], e_err);
      chk($sformatf("at_min[%0d]", k), amin[k], mv[k] == MIN_V);
      chk($sformatf("at_max[%0d]", k), amax[k], mv[k] == MAX_V);
    end
  endtask

  typedef struct {
    bit         ka, ks, ld;
    logic [7:0] lv, ew, es;
    bit         stw, limw, sts, lims, err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit ka, ks, ld, input logic [7:0] lv, ew, es,
                     input bit stw, limw, sts, lims, err);
    vec_t v;
    v.ka = ka; v.ks = ks; v.ld = ld; v.lv = lv; v.ew = ew; v.es = es;
    v.stw = stw; v.limw = limw; v.sts = sts; v.lims = lims; v.err = err;
    tbl.push_back(v);
  endtask

  int expv;

  initial begin
    //   ka ks ld  lv     wrap   sat    stw limw sts lims err
    add(0, 0, 1, 8'h09, 8'h09, 8'h09, 1, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 8'h10, 8'h10, 1, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 8'h10, 8'h10, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8'h10, 8'h10, 0, 0, 0, 0, 0);
    add(0, 0, 1, 8'h60, 8'h60, 8'h60, 1, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 8'h01, 8'h60, 1, 1, 0, 1, 0);
    add(0, 0, 1, 8'h01, 8'h01, 8'h01, 0, 0, 1, 0, 0);
    add(0, 1, 0, 8'h00, 8'h60, 8'h01, 1, 1, 0, 1, 0);
    add(0, 0, 1, 8'h45, 8'h45, 8'h45, 1, 0, 1, 0, 0);
    add(0, 0, 1, 8'h4A, 8'h45, 8'h45, 0, 0, 0, 0, 1);
    add(0, 0, 1, 8'h75, 8'h45, 8'h45, 0, 0, 0, 0, 1);
    add(1, 0, 1, 8'h50, 8'h50, 8'h50, 1, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0, 0, 0);
    add(1, 1, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 8'h50, 8'h50, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 8'h49, 8'h49, 1, 0, 1, 0, 0);
    add(0, 0, 1, 8'h00, 8'h49, 8'h49, 0, 0, 0, 0, 1);
    add(0, 0, 1, 8'h61, 8'h49, 8'h49, 0, 0, 0, 0, 1);

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("reset set_val", sv[0], 8'h02);
    chk("reset at_min", amin[0], 1'b0);
    chk("reset at_max", amax[0], 1'b0);
    chk("reset step_p", stp[0], 1'b0);
    chk("reset limit_p", lmp[0], 1'b0);
    chk("reset load_err", lerr[0], 1'b0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      key_add = tbl[i].ka;
      key_sub = tbl[i].ks;
      load = tbl[i].ld;
      load_val = tbl[i].lv;
      tick();
      chk($sformatf("vec%0d wrap val", i), sv[0], tbl[i].ew);
      chk($sformatf("vec%0d sat val", i), sv[1], tbl[i].es);
      chk($sformatf("vec%0d wrap step", i), stp[0], tbl[i].stw);
      chk($sformatf("vec%0d wrap limit", i), lmp[0], tbl[i].limw);
      chk($sformatf("vec%0d sat step", i), stp[1], tbl[i].sts);
      chk($sformatf("vec%0d sat limit", i), lmp[1], tbl[i].lims);
      chk($sformatf("vec%0d load_err", i), lerr[0], tbl[i].err);
    end
    key_add = 1'b0;
    key_sub = 1'b0;
    load = 1'b0;
    tick();

    // Long hold of key_add from 10
    load = 1'b1;
    load_val = 8'h10;
    tick();
    load = 1'b0;
    key_add = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      expv = 11;
`ifdef BCD_SETPOINT_AUTOREPEAT_EN
      if (i >= HD) expv = 12 + (i - HD) / RP;
`endif
      chk($sformatf("hold cycle %0d", i), sv[0], bcd(expv));
    end
    key_add = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("release cycle %0d", i), sv[0], bcd(expv));
    end

    // Asynchronous reset in the middle of a press
    key_add = 1'b1;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("async rst wrap", sv[0], 8'h02);
    chk("async rst sat", sv[1], 8'h02);
    chk("async rst step_p", stp[0], 1'b0);
    key_add = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) key_add = ~key_add;
      if ($urandom_range(0, 5) == 0) key_sub = ~key_sub;
      load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) load_val = bcd($urandom_range(0, 99));
      else load_val = 8'($urandom);
      tick();
    end
    load = 1'b0;
    key_add = 1'b0;
    key_sub = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
